// File: rtl/rd_pntrs_and_empty.sv
// Read-side pointer and status block of a dual-clock FIFO. Everything here
// runs in the read clock domain.
//
// Synchronises the Gray write pointer from the write domain and keeps the
// binary and Gray read pointers. Produces the RAM read address, a registered
// empty flag, a read-side fill level and a read-data-valid strobe for a RAM
// with 1-cycle read latency.
//
// Ports:
//   rd_clk_i           read clock, rising edge
//   srst_i             synchronous reset, active-high, overrides all inputs
//   rd_req_i           read request from the consumer
//   wr_pntr_gray_i     Gray write pointer, asynchronous to rd_clk_i
//   rd_pntr_o          RAM read address (low AWIDTH bits of the binary read pointer)
//   rd_pntr_gray_wr_o  registered Gray read pointer for the write domain
//   rd_empty_o         FIFO empty, registered
//   rd_usedw_o         words in the FIFO as seen from the read side
//   rd_valid_o         RAM read data valid, the cycle after an accepted read
module rd_pntrs_and_empty #(
    parameter int unsigned AWIDTH      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              rd_clk_i,
    input  logic              srst_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic [AWIDTH:0]   rd_pntr_gray_wr_o,
    output logic              rd_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_valid_o
);

    logic [AWIDTH:0] rd_pntr_bin_q, rd_pntr_bin_d;
    logic [AWIDTH:0] rd_pntr_gray_q, rd_pntr_gray_d;
    logic            rd_empty_q, rd_empty_d;
    logic [AWIDTH:0] rd_usedw_q, rd_usedw_d;
    logic            rd_valid_q, rd_valid_d;
    logic [AWIDTH:0] wr_sync_q [SYNC_STAGES];
    logic [AWIDTH:0] wr_sync_d [SYNC_STAGES];

    logic            rd_ack;
    logic [AWIDTH:0] wr_gray_s;
    logic [AWIDTH:0] wr_bin_s;

    always_comb begin
        // Reads are only accepted when not empty, so the pointer never passes
        // the synchronised write pointer.
        rd_ack        = rd_req_i & ~rd_empty_q;
        rd_pntr_bin_d = rd_pntr_bin_q + {{AWIDTH{1'b0}}, rd_ack};
        rd_pntr_gray_d = rd_pntr_bin_d ^ (rd_pntr_bin_d >> 1);

        // Plain flop chain; no logic ahead of the first stage.
        wr_sync_d[0] = wr_pntr_gray_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            wr_sync_d[k] = wr_sync_q[k-1];
        end
        wr_gray_s = wr_sync_q[SYNC_STAGES-1];

        // Gray to binary: bit i is the XOR of all Gray bits at and above i.
        wr_bin_s = '0;
        for (int i = 0; i <= AWIDTH; i++) begin
            wr_bin_s[i] = ^(wr_gray_s >> i);
        end

        // Status uses the post-read pointer so a read of the last word flags
        // empty on the same edge.
        rd_empty_d = (rd_pntr_gray_d == wr_gray_s);
        // Extra wrap bit lets a full FIFO report 2**AWIDTH instead of 0.
        rd_usedw_d = wr_bin_s - rd_pntr_bin_d;
        rd_valid_d = rd_ack;
    end

    always_ff @(posedge rd_clk_i) begin
        if (srst_i) begin
            rd_pntr_bin_q  <= '0;
            rd_pntr_gray_q <= '0;
            rd_empty_q     <= 1'b1;
            rd_usedw_q     <= '0;
            rd_valid_q     <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                wr_sync_q[k] <= '0;
            end
        end else begin
            rd_pntr_bin_q  <= rd_pntr_bin_d;
            rd_pntr_gray_q <= rd_pntr_gray_d;
            rd_empty_q     <= rd_empty_d;
            rd_usedw_q     <= rd_usedw_d;
            rd_valid_q     <= rd_valid_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                wr_sync_q[k] <= wr_sync_d[k];
            end
        end
    end

    assign rd_pntr_o         = rd_pntr_bin_q[AWIDTH-1:0];
    assign rd_pntr_gray_wr_o = rd_pntr_gray_q;
    assign rd_empty_o        = rd_empty_q;
    assign rd_usedw_o        = rd_usedw_q;
    assign rd_valid_o        = rd_valid_q;

endmodule
